// File: rtl/uart_dl_pkg.sv
// Shared types and constants for the UART debug download loader.
// Holds the FSM state encoding, the response bytes and the CRC16/MODBUS parameters.
package uart_dl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_SEQ    = 4'd1,
        ST_DATA   = 4'd2,
        ST_CRC_LO = 4'd3,
        ST_CRC_HI = 4'd4,
        ST_CHECK  = 4'd5,
        ST_COMMIT = 4'd6,
        ST_RESP   = 4'd7,
        ST_DONE   = 4'd8
    } dl_state_e;

    localparam logic [7:0]  ACK_BYTE = 8'h06;
    localparam logic [7:0]  NAK_BYTE = 8'h15;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'hA001;

endpackage

// File: rtl/uart_dl_loader_if.sv
// Byte-stream and ROM-write bundle between the loader and the SoC fabric.
// The loader takes the master modport; the UART engines and ROM side take slave.
interface uart_dl_loader_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;

    modport master (
        input  rx_valid_i, rx_data_i, tx_ready_i,
        output tx_valid_o, tx_data_o, mem_we_o, mem_addr_o, mem_data_o
    );

    modport slave (
        output rx_valid_i, rx_data_i, tx_ready_i,
        input  tx_valid_o, tx_data_o, mem_we_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/crc16_modbus_byte.sv
// One-byte CRC16/MODBUS update: reflected polynomial, LSB first, eight unrolled steps.
module crc16_modbus_byte
    import uart_dl_pkg::*;
(
    input  logic [15:0] crc,
    input  logic [7:0]  data,
    output logic [15:0] crc_next
);

    logic [15:0] crc_s;

    // eight shift/xor steps of the reflected CRC register
    always_comb begin
        crc_s = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (crc_s[0]) begin
                crc_s = (crc_s >> 1) ^ CRC_POLY;
            end else begin
                crc_s = crc_s >> 1;
            end
        end
    end

    assign crc_next = crc_s;

endmodule

// File: rtl/uart_dl_loader.sv
// Packet framer, CRC checker and ROM committer for the UART debug download stream.
// Each packet is answered with ACK/NAK; the core is held while the download runs.
module uart_dl_loader
    import uart_dl_pkg::*;
#(
    parameter int          PKT_DATA_BYTES = 128,
    parameter int          FSIZE_IDX      = 60,
    parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
    parameter int          MAX_BYTES      = 4096,
    parameter int          TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug_en_i,
    uart_dl_loader_if.master  bus,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int             WORDS     = PKT_DATA_BYTES / 4;
    localparam int             BW        = $clog2(PKT_DATA_BYTES);
    localparam int             WW        = $clog2(WORDS);
    localparam logic [BW-1:0]  LAST_BYTE = BW'(PKT_DATA_BYTES - 1);
    localparam logic [WW-1:0]  LAST_WORD = WW'(WORDS - 1);
    localparam logic [31:0]    PKT_BYTES = 32'(PKT_DATA_BYTES);

    dl_state_e     state_r, state_s;
    logic [7:0]    seq_r, exp_seq_r;
    logic [15:0]   crc_r, crc_rx_r, crc_next_s;
    logic [BW-1:0] byte_cnt_r;
    logic [WW-1:0] wcnt_r, wcnt_s;
    logic [31:0]   buf_r [WORDS];
    logic [31:0]   fsize_r, base_r, idle_cnt_r, next_off_s, fsize_rx_s;
    logic          ack_r, ack_s, last_r, last_s, err_s;
    logic          in_frame_s, timeout_s, crc_ok_s;
    logic          tx_valid_r, mem_we_r, busy_r, done_r, err_r;
    logic [7:0]    tx_data_r;
    logic [31:0]   mem_addr_r, mem_data_r;

    crc16_modbus_byte u_crc (
        .crc      (crc_r),
        .data     (bus.rx_data_i),
        .crc_next (crc_next_s)
    );

    assign in_frame_s = (state_r == ST_DATA) || (state_r == ST_CRC_LO) || (state_r == ST_CRC_HI);
    assign timeout_s  = in_frame_s && !bus.rx_valid_i && (idle_cnt_r >= 32'(TIMEOUT_CYCLES));
    assign crc_ok_s   = (crc_rx_r == crc_r);
    assign next_off_s = base_r + ((32'(wcnt_r) + 32'd1) << 2);
    // file size sits big-endian at a fixed payload offset of packet 0
    assign fsize_rx_s = {buf_r[FSIZE_IDX/4][8*(FSIZE_IDX%4) +: 8],
                         buf_r[(FSIZE_IDX+1)/4][8*((FSIZE_IDX+1)%4) +: 8],
                         buf_r[(FSIZE_IDX+2)/4][8*((FSIZE_IDX+2)%4) +: 8],
                         buf_r[(FSIZE_IDX+3)/4][8*((FSIZE_IDX+3)%4) +: 8]};

    // next-state and response decision logic
    always_comb begin
        state_s = state_r;
        ack_s   = ack_r;
        last_s  = last_r;
        err_s   = 1'b0;
        wcnt_s  = {WW{1'b0}};
        if (!debug_en_i) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   state_s = ST_SEQ;
                ST_SEQ:    state_s = bus.rx_valid_i ? ST_DATA : ST_SEQ;
                ST_DATA:   state_s = (bus.rx_valid_i && byte_cnt_r == LAST_BYTE) ? ST_CRC_LO : ST_DATA;
                ST_CRC_LO: state_s = bus.rx_valid_i ? ST_CRC_HI : ST_CRC_LO;
                ST_CRC_HI: state_s = bus.rx_valid_i ? ST_CHECK : ST_CRC_HI;
                ST_CHECK: begin
                    last_s  = 1'b0;
                    state_s = ST_RESP;
                    if (exp_seq_r == 8'h00) begin
                        if (crc_ok_s && seq_r == 8'h00 && fsize_rx_s != 32'd0 &&
                            fsize_rx_s <= 32'(MAX_BYTES)) begin
                            ack_s = 1'b1;
                        end else begin
                            ack_s = 1'b0;
                            err_s = 1'b1;
                        end
                    end else if (crc_ok_s && seq_r == exp_seq_r) begin
                        ack_s   = 1'b1;
                        state_s = ST_COMMIT;
                    end else if (crc_ok_s && seq_r == exp_seq_r - 8'd1) begin
                        ack_s = 1'b1;
                    end else begin
                        ack_s = 1'b0;
                        err_s = 1'b1;
                    end
                end
                ST_COMMIT: begin
                    wcnt_s = wcnt_r + {{(WW-1){1'b0}}, 1'b1};
                    if (wcnt_r == LAST_WORD || next_off_s >= fsize_r) begin
                        state_s = ST_RESP;
                        last_s  = (base_r + PKT_BYTES >= fsize_r);
                    end else begin
                        state_s = ST_COMMIT;
                    end
                end
                ST_RESP:   state_s = bus.tx_ready_i ? (last_r ? ST_DONE : ST_SEQ) : ST_RESP;
                ST_DONE:   state_s = ST_DONE;
                default:   state_s = ST_IDLE;
            endcase
            if (timeout_s) begin
                state_s = ST_RESP;
                ack_s   = 1'b0;
                last_s  = 1'b0;
                err_s   = 1'b1;
            end else begin
                err_s = err_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // packet datapath: sequence, CRC, payload buffer, progress counters
    always_ff @(posedge clk) begin
        if (rst || !debug_en_i) begin
            seq_r      <= 8'h00;
            exp_seq_r  <= 8'h00;
            crc_r      <= CRC_INIT;
            crc_rx_r   <= 16'h0000;
            byte_cnt_r <= {BW{1'b0}};
            wcnt_r     <= {WW{1'b0}};
            fsize_r    <= 32'd0;
            base_r     <= 32'd0;
            idle_cnt_r <= 32'd0;
            ack_r      <= 1'b0;
            last_r     <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                buf_r[i] <= 32'd0;
            end
        end else begin
            ack_r      <= ack_s;
            last_r     <= last_s;
            wcnt_r     <= wcnt_s;
            idle_cnt_r <= (in_frame_s && !bus.rx_valid_i) ? idle_cnt_r + 32'd1 : 32'd0;
            case (state_r)
                ST_SEQ: if (bus.rx_valid_i) begin
                    seq_r      <= bus.rx_data_i;
                    crc_r      <= CRC_INIT;
                    byte_cnt_r <= {BW{1'b0}};
                end
                ST_DATA: if (bus.rx_valid_i) begin
                    crc_r      <= crc_next_s;
                    buf_r[byte_cnt_r[BW-1:2]][{byte_cnt_r[1:0], 3'b000} +: 8] <= bus.rx_data_i;
                    byte_cnt_r <= byte_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                end
                ST_CRC_LO: if (bus.rx_valid_i) crc_rx_r[7:0]  <= bus.rx_data_i;
                ST_CRC_HI: if (bus.rx_valid_i) crc_rx_r[15:8] <= bus.rx_data_i;
                ST_CHECK: if (exp_seq_r == 8'h00 && ack_s) begin
                    fsize_r   <= fsize_rx_s;
                    exp_seq_r <= 8'h01;
                end
                ST_COMMIT: if (state_s == ST_RESP) begin
                    base_r    <= base_r + PKT_BYTES;
                    exp_seq_r <= exp_seq_r + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (rst || !debug_en_i) begin
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
            mem_we_r   <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_data_r <= 32'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            tx_valid_r <= (state_s == ST_RESP);
            tx_data_r  <= (state_s == ST_RESP) ? (ack_s ? ACK_BYTE : NAK_BYTE) : 8'h00;
            mem_we_r   <= (state_s == ST_COMMIT);
            mem_addr_r <= (state_s == ST_COMMIT) ? ROM_BASE + base_r + (32'(wcnt_s) << 2) : 32'd0;
            mem_data_r <= (state_s == ST_COMMIT) ? buf_r[wcnt_s] : 32'd0;
            busy_r     <= (state_s != ST_DONE);
            done_r     <= (state_s == ST_DONE);
            err_r      <= err_s;
        end
    end

    // write strobe is gated directly so dropping debug mode cuts a commit in the same cycle
    assign bus.mem_we_o   = mem_we_r & debug_en_i;
    assign bus.mem_addr_o = mem_addr_r;
    assign bus.mem_data_o = mem_data_r;
    assign bus.tx_valid_o = tx_valid_r;
    assign bus.tx_data_o  = tx_data_r;
    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign err_o          = err_r;

endmodule

// File: tb/tb_uart_dl_loader.sv
// Directed self-checking bench for uart_dl_loader: framing, CRC, commit, duplicates,
// timeout and debug-enable abort, with hand-computed responses and ROM writes.
module tb_uart_dl_loader;
    import uart_dl_pkg::*;

    localparam int PKT = 128;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic debug_en = 1'b0;
    logic busy, done, err;

    uart_dl_loader_if bus();

    uart_dl_loader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .debug_en_i (debug_en),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    logic [15:0] cu_crc, cu_next;
    logic [7:0]  cu_byte;
    crc16_modbus_byte u_crc_unit (.crc(cu_crc), .data(cu_byte), .crc_next(cu_next));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  pl [PKT];
    logic [7:0]  r;
    bit          got;
    int          n0, e0;

    // ROM write and error pulse monitor
    always @(negedge clk) begin
        if (bus.mem_we_o) begin
            wr_addr.push_back(bus.mem_addr_o);
            wr_data.push_back(bus.mem_data_o);
        end
        if (err) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        tick();
        bus.rx_valid_i = 1'b0;
        tick();
    endtask

    // bit-serial CRC16/MODBUS reference, data fed LSB first
    function automatic logic [15:0] crc_model(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        logic fb;
        x = c;
        for (int j = 0; j < 8; j++) begin
            fb = x[0] ^ b[j];
            x  = x >> 1;
            if (fb) x = x ^ 16'hA001;
        end
        return x;
    endfunction

    task automatic fill_pattern(input logic [7:0] x);
        for (int i = 0; i < PKT; i++) pl[i] = 8'(i) ^ x;
    endtask

    task automatic fill_hdr(input logic [31:0] size);
        for (int i = 0; i < PKT; i++) pl[i] = 8'h00;
        pl[60] = size[31:24];
        pl[61] = size[23:16];
        pl[62] = size[15:8];
        pl[63] = size[7:0];
    endtask

    task automatic send_pkt(input logic [7:0] seq, input int nbytes, input bit bad);
        logic [15:0] c;
        c = 16'hFFFF;
        send_byte(seq);
        for (int i = 0; i < nbytes; i++) begin
            c = crc_model(c, pl[i]);
            send_byte(pl[i]);
        end
        if (nbytes == PKT) begin
            send_byte(c[7:0]);
            send_byte(bad ? (c[15:8] ^ 8'hFF) : c[15:8]);
        end
    endtask

    // waits (bounded) for a response; valid must stay up two cycles before it is accepted
    task automatic wait_resp(output logic [7:0] b, output bit ok);
        b  = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.tx_valid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) begin
            tick();
            tick();
            ok = bus.tx_valid_o;
            b  = bus.tx_data_o;
            bus.tx_ready_i = 1'b1;
            tick();
            bus.tx_ready_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_crc_unit();
        cu_crc = 16'hFFFF;
        for (int i = 0; i < 9; i++) begin
            cu_byte = 8'h31 + 8'(i);
            #1;
            cu_crc = cu_next;
        end
        #1;
        checks++;
        if (cu_crc !== 16'h4B37) begin
            errors++;
            $display("FAIL crc_123456789 got=%h exp=4b37", cu_crc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        debug_en = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.tx_valid_o, bus.mem_we_o, busy, done, err, bus.tx_data_o} !== 13'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0",
                     {bus.tx_valid_o, bus.mem_we_o, busy, done, err, bus.tx_data_o});
        end
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL busy_after_reset got=%b exp=10", {busy, done});
        end
    endtask

    task automatic test_basic();
        n0 = wr_addr.size();
        fill_hdr(32'd8);
        send_pkt(8'd0, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== ACK_BYTE || wr_addr.size() != n0) begin
            errors++;
            $display("FAIL pkt0_ack got=%0b resp=%h writes=%0d exp resp=06 writes=0", got, r, wr_addr.size() - n0);
        end
        for (int i = 0; i < PKT; i++) pl[i] = 8'h00;
        pl[0] = 8'h13; pl[4] = 8'h93; pl[6] = 8'h10;
        e0 = err_cnt;
        send_pkt(8'd1, PKT, 1'b1);
        wait_resp(r, got);
        checks++;
        if (!got || r !== NAK_BYTE || err_cnt - e0 != 1 || wr_addr.size() != n0) begin
            errors++;
            $display("FAIL bad_crc_nak got=%0b resp=%h errs=%0d writes=%0d exp resp=15 errs=1 writes=0",
                     got, r, err_cnt - e0, wr_addr.size() - n0);
        end
        send_pkt(8'd1, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== ACK_BYTE || wr_addr.size() - n0 != 2) begin
            errors++;
            $display("FAIL pkt1_ack got=%0b resp=%h writes=%0d exp resp=06 writes=2", got, r, wr_addr.size() - n0);
        end
        checks++;
        if ({wr_addr[n0], wr_data[n0], wr_addr[n0+1], wr_data[n0+1]} !==
            {32'h0, 32'h0000_0013, 32'h4, 32'h0010_0093}) begin
            errors++;
            $display("FAIL pkt1_words got=%h:%h %h:%h exp=0:00000013 4:00100093",
                     wr_addr[n0], wr_data[n0], wr_addr[n0+1], wr_data[n0+1]);
        end
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL done_small got done,busy=%b exp=10", {done, busy});
        end
    endtask

    task automatic test_dup_seq();
        debug_en = 1'b0;
        tick();
        debug_en = 1'b1;
        tick();
        checks++;
        if ({done, busy} !== 2'b01) begin
            errors++;
            $display("FAIL reenable got done,busy=%b exp=01", {done, busy});
        end
        fill_hdr(32'd298);
        send_pkt(8'd0, PKT, 1'b0);
        wait_resp(r, got);
        fill_pattern(8'h00);
        n0 = wr_addr.size();
        send_pkt(8'd1, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== ACK_BYTE || wr_addr.size() - n0 != 32 ||
            {wr_addr[n0], wr_data[n0], wr_addr[n0+31], wr_data[n0+31]} !==
            {32'h0, 32'h0302_0100, 32'h7C, 32'h7F7E_7D7C}) begin
            errors++;
            $display("FAIL full_pkt1 resp=%h writes=%0d first=%h:%h last=%h:%h exp 06 32 0:03020100 7c:7f7e7d7c",
                     r, wr_addr.size() - n0, wr_addr[n0], wr_data[n0], wr_addr[n0+31], wr_data[n0+31]);
        end
        n0 = wr_addr.size();
        send_pkt(8'd1, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== ACK_BYTE || wr_addr.size() != n0) begin
            errors++;
            $display("FAIL duplicate got=%0b resp=%h writes=%0d exp resp=06 writes=0", got, r, wr_addr.size() - n0);
        end
        e0 = err_cnt;
        send_pkt(8'd3, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== NAK_BYTE || err_cnt - e0 != 1 || wr_addr.size() != n0) begin
            errors++;
            $display("FAIL seq_skip got=%0b resp=%h errs=%0d writes=%0d exp resp=15 errs=1 writes=0",
                     got, r, err_cnt - e0, wr_addr.size() - n0);
        end
        fill_pattern(8'h80);
        send_pkt(8'd2, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== ACK_BYTE || wr_addr.size() - n0 != 32 ||
            {wr_addr[n0], wr_data[n0]} !== {32'h80, 32'h8382_8180}) begin
            errors++;
            $display("FAIL pkt2 resp=%h writes=%0d first=%h:%h exp 06 32 80:83828180",
                     r, wr_addr.size() - n0, wr_addr[n0], wr_data[n0]);
        end
    endtask

    task automatic test_timeout();
        fill_pattern(8'h00);
        e0 = err_cnt;
        send_pkt(8'd3, 50, 1'b0);
        repeat (TMO - 10) tick();
        checks++;
        if (bus.tx_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL early_timeout got tx_valid=%b exp=0", bus.tx_valid_o);
        end
        wait_resp(r, got);
        checks++;
        if (!got || r !== NAK_BYTE || err_cnt - e0 != 1) begin
            errors++;
            $display("FAIL timeout_nak got=%0b resp=%h errs=%0d exp resp=15 errs=1", got, r, err_cnt - e0);
        end
        n0 = wr_addr.size();
        send_pkt(8'd3, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== ACK_BYTE || wr_addr.size() - n0 != 11 ||
            {wr_addr[n0], wr_data[n0], wr_addr[n0+10], wr_data[n0+10]} !==
            {32'h100, 32'h0302_0100, 32'h128, 32'h2B2A_2928}) begin
            errors++;
            $display("FAIL last_pkt resp=%h writes=%0d first=%h:%h last=%h:%h exp 06 11 100:03020100 128:2b2a2928",
                     r, wr_addr.size() - n0, wr_addr[n0], wr_data[n0], wr_addr[n0+10], wr_data[n0+10]);
        end
        repeat (5) tick();
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL done_sticky got done,busy=%b exp=10", {done, busy});
        end
    endtask

    task automatic test_disable();
        debug_en = 1'b0;
        tick();
        debug_en = 1'b1;
        tick();
        fill_hdr(32'd300);
        send_pkt(8'd0, PKT, 1'b0);
        wait_resp(r, got);
        fill_pattern(8'h00);
        send_pkt(8'd1, 60, 1'b0);
        debug_en = 1'b0;
        tick();
        checks++;
        if ({bus.tx_valid_o, bus.mem_we_o, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL drop_mid_data got=%b exp=0", {bus.tx_valid_o, bus.mem_we_o, busy, done, err});
        end
        debug_en = 1'b1;
        tick();
        fill_hdr(32'd300);
        send_pkt(8'd0, PKT, 1'b0);
        wait_resp(r, got);
        fill_pattern(8'h00);
        n0 = wr_addr.size();
        send_pkt(8'd1, PKT, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_we_o) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        debug_en = 1'b0;
        #1;
        checks++;
        if (!got || bus.mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_mid_commit saw_commit=%0b we=%b exp saw=1 we=0", got, bus.mem_we_o);
        end
        repeat (5) tick();
        checks++;
        if (wr_addr.size() != n0 || {bus.tx_valid_o, busy, done} !== 3'b0) begin
            errors++;
            $display("FAIL after_commit_drop writes=%0d outs=%b exp writes=0 outs=0",
                     wr_addr.size() - n0, {bus.tx_valid_o, busy, done});
        end
        debug_en = 1'b1;
        tick();
        e0 = err_cnt;
        send_pkt(8'd1, PKT, 1'b0);
        wait_resp(r, got);
        checks++;
        if (!got || r !== NAK_BYTE || err_cnt - e0 != 1 || wr_addr.size() != n0) begin
            errors++;
            $display("FAIL pkt1_before_pkt0 got=%0b resp=%h errs=%0d writes=%0d exp resp=15 errs=1 writes=0",
                     got, r, err_cnt - e0, wr_addr.size() - n0);
        end
    endtask

    initial begin
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        bus.tx_ready_i = 1'b0;
        cu_crc  = 16'hFFFF;
        cu_byte = 8'h00;
        test_crc_unit();
        test_reset();
        test_basic();
        test_dup_seq();
        test_timeout();
        test_disable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
